lcd_src_sched: RTL and testbench

//  Frame-level scheduler for the memory-LCD read path. Sits between the sync FIFO read port and memlcd_fsm.

---
 rtl/lcd_src_sched_pkg.sv | 23 ++
 rtl/lcd_src_sched_pat_gen.sv | 21 ++
 rtl/lcd_src_sched.sv | 144 ++++++++++++++
 tb/tb_lcd_src_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_src_sched_pkg.sv
// Shared types and constants for the memory-LCD source scheduler and its pattern generator.
package lcd_src_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOST = 2'd1,
    ST_PAT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'd0,
    PAT_WHITE = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_RAMP  = 2'd3
  } pat_e;

  // 6-bit RGB colour bytes as seen by the panel
  localparam logic [7:0] RGB_BLACK   = 8'h00;
  localparam logic [7:0] RGB_WHITE   = 8'h3F;
  localparam logic [7:0] RGB_CHECK_A = 8'h2A;
  localparam logic [7:0] RGB_CHECK_B = 8'h15;

endpackage

// File: rtl/lcd_src_sched_pat_gen.sv
// Combinational test-pattern byte generator: (pattern code, byte index) -> pixel byte.
module lcd_src_sched_pat_gen
  import lcd_src_sched_pkg::*;
(
  input  logic [1:0] sel_i,
  input  logic [7:0] cnt_i,
  output logic [7:0] data_o
);

  always_comb begin
    data_o = RGB_BLACK;
    case (pat_e'(sel_i))
      PAT_BLACK: data_o = RGB_BLACK;
      PAT_WHITE: data_o = RGB_WHITE;
      PAT_CHECK: data_o = cnt_i[0] ? RGB_CHECK_A : RGB_CHECK_B;
      PAT_RAMP:  data_o = cnt_i;
      default:   data_o = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/lcd_src_sched.sv
// Frame-level source scheduler between the sync FIFO read port and memlcd_fsm.
// Optional host-underrun watchdog enabled by defining LCD_SRC_SCHED_TIMEOUT_EN.
module lcd_src_sched
  import lcd_src_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FRAME_BYTES = 19200,
  parameter int CNT_W       = 15,
  parameter int TIMEOUT     = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
  input  logic                  i_fifo_rempty,
  output logic                  o_fifo_rinc,
  input  logic                  i_lcd_rinc,
  output logic [DATA_WIDTH-1:0] o_lcd_data,
  output logic                  o_lcd_rempty,
  input  logic                  i_pat_req,
  input  logic [1:0]            i_pat_sel,
  output logic                  o_src,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_underrun
);

  if ((2 ** CNT_W) < FRAME_BYTES || TIMEOUT < 1 || DATA_WIDTH < 8) begin : g_param_err
    $error("lcd_src_sched: inconsistent CNT_W/FRAME_BYTES/TIMEOUT/DATA_WIDTH");
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pend_q;
  logic [1:0]       pend_sel_q;
  logic [1:0]       frame_sel_q;
  logic             src_q;
  logic             done_q;

  logic [7:0]       pat_byte;
  logic             accept;
  logic             last_byte;

  lcd_src_sched_pat_gen u_pat_gen (
    .sel_i  (frame_sel_q),
    .cnt_i  (8'(cnt_q)),
    .data_o (pat_byte)
  );

  always_comb begin
    o_lcd_data   = '0;
    o_lcd_rempty = 1'b1;
    o_fifo_rinc  = 1'b0;
    case (state_q)
      ST_HOST: begin
        o_lcd_data   = i_fifo_rdata;
        o_lcd_rempty = i_fifo_rempty;
        o_fifo_rinc  = i_lcd_rinc & ~i_fifo_rempty;
      end
      ST_PAT: begin
        o_lcd_data   = DATA_WIDTH'(pat_byte);
        o_lcd_rempty = 1'b0;
      end
      default: ;
    endcase
  end

  assign accept    = i_lcd_rinc & ~o_lcd_rempty;
  assign last_byte = (cnt_q == CNT_W'(FRAME_BYTES - 1));

  // The pattern code is frozen per frame so a new request cannot change a frame in flight.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_sel_q  <= 2'd0;
      frame_sel_q <= 2'd0;
      src_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_pat_req) begin
        pend_q     <= 1'b1;
        pend_sel_q <= i_pat_sel;
      end
      case (state_q)
        ST_IDLE: begin
          if (pend_q) begin
            state_q     <= ST_PAT;
            src_q       <= 1'b1;
            frame_sel_q <= pend_sel_q;
            cnt_q       <= '0;
            if (!i_pat_req) pend_q <= 1'b0;
          end else if (!i_fifo_rempty) begin
            state_q <= ST_HOST;
            src_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        ST_HOST, ST_PAT: begin
          if (accept) begin
            if (last_byte) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_src        = src_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_done = done_q;

`ifdef LCD_SRC_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wdog_q;
  logic            underrun_q;

  // Saturating count of consecutive starved HOST cycles; the frame keeps waiting.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wdog_q     <= '0;
      underrun_q <= 1'b0;
    end else if (state_q == ST_HOST && i_fifo_rempty) begin
      if (wdog_q != WD_W'(TIMEOUT)) wdog_q <= wdog_q + 1'b1;
      if (wdog_q == WD_W'(TIMEOUT - 1)) underrun_q <= 1'b1;
    end else begin
      wdog_q <= '0;
    end
  end

  assign o_underrun = underrun_q;
`else
  assign o_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_src_sched.sv
// Self-checking bench for lcd_src_sched with a small frame size and a FIFO/scoreboard model.
module tb_lcd_src_sched;

  localparam int FB = 16;
`ifdef LCD_SRC_SCHED_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       i_clk;
  logic       i_reset;
  logic [7:0] i_fifo_rdata;
  logic       i_fifo_rempty;
  logic       o_fifo_rinc;
  logic       i_lcd_rinc;
  logic [7:0] o_lcd_data;
  logic       o_lcd_rempty;
  logic       i_pat_req;
  logic [1:0] i_pat_sel;
  logic       o_src;
  logic       o_busy;
  logic       o_frame_done;
  logic       o_underrun;

  lcd_src_sched #(
    .DATA_WIDTH (8),
    .FRAME_BYTES(FB),
    .CNT_W      (4),
    .TIMEOUT    (1024)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_fifo_rdata (i_fifo_rdata),
    .i_fifo_rempty(i_fifo_rempty),
    .o_fifo_rinc  (o_fifo_rinc),
    .i_lcd_rinc   (i_lcd_rinc),
    .o_lcd_data   (o_lcd_data),
    .o_lcd_rempty (o_lcd_rempty),
    .i_pat_req    (i_pat_req),
    .i_pat_sel    (i_pat_sel),
    .o_src        (o_src),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_underrun   (o_underrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] even_b;
    logic [7:0] odd_b;
    bit         ramp;
  } pat_vec_t;

  pat_vec_t   pat_tab[4];
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         rinc_total = 0;
  bit         last_acc = 1'b0;
  bit         rst_v = 1'b0;
  logic       done_src;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1ns later, model FIFO pops and score accepted bytes.
  task automatic cyc(input bit rinc, input bit preq = 1'b0, input logic [1:0] psel = 2'd0);
    @(negedge i_clk);
    i_reset       = rst_v;
    i_lcd_rinc    = rinc;
    i_pat_req     = preq;
    i_pat_sel     = psel;
    i_fifo_rempty = (fifo_q.size() == 0);
    i_fifo_rdata  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    #1;
    last_acc = rinc && (o_lcd_rempty === 1'b0);
    if (o_fifo_rinc === 1'b1) begin
      rinc_total++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (last_acc) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: got byte %0h with nothing expected", o_lcd_data);
      end else begin
        check("lcd_data", o_lcd_data, exp_q.pop_front());
      end
    end
  endtask

  task automatic push_pattern(input logic [1:0] sel);
    for (int i = 0; i < FB; i++) begin
      if (pat_tab[sel].ramp) exp_q.push_back(8'(i));
      else exp_q.push_back((i % 2 == 1) ? pat_tab[sel].odd_b : pat_tab[sel].even_b);
    end
  endtask

  task automatic push_host(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + 8'(i));
      exp_q.push_back(base + 8'(i));
    end
  endtask

  // Pops n bytes with the LCD reading every cycle, optionally firing pattern requests at given byte indices.
  task automatic run_frame(input string nm, input int n = FB,
                           input int req_a = -1, input logic [1:0] sel_a = 2'd0,
                           input int req_b = -1, input logic [1:0] sel_b = 2'd0);
    int         got = 0;
    int         cycles = 0;
    bit         early = 1'b0;
    bit         fa = 1'b0;
    bit         fb = 1'b0;
    bit         pr;
    logic [1:0] ps;
    while (got < n && cycles < 400) begin
      pr = 1'b0;
      ps = 2'd0;
      if (!fa && got == req_a) begin
        pr = 1'b1; ps = sel_a; fa = 1'b1;
      end else if (!fb && got == req_b) begin
        pr = 1'b1; ps = sel_b; fb = 1'b1;
      end
      cyc(1'b1, pr, ps);
      if (got > 0 && o_frame_done !== 1'b0) early = 1'b1;
      if (last_acc) got++;
      cycles++;
    end
    check({nm, "_bytes"}, got, n);
    check({nm, "_early_done"}, early, 0);
    cyc(1'b0);
    check({nm, "_done"}, o_frame_done, 1);
    check({nm, "_idle_busy"}, o_busy, 0);
    done_src = o_src;
    cyc(1'b0);
    check({nm, "_done_single"}, o_frame_done, 0);
  endtask

  initial begin
    int r0;
    int got;
    int busy_seen;

    pat_tab[0] = '{2'd0, 8'h00, 8'h00, 1'b0};
    pat_tab[1] = '{2'd1, 8'h3F, 8'h3F, 1'b0};
    pat_tab[2] = '{2'd2, 8'h15, 8'h2A, 1'b0};
    pat_tab[3] = '{2'd3, 8'h00, 8'h00, 1'b1};

    i_reset = 1'b0; i_lcd_rinc = 1'b0; i_pat_req = 1'b0; i_pat_sel = 2'd0;
    i_fifo_rempty = 1'b1; i_fifo_rdata = 8'h00;

    rst_v = 1'b0;
    repeat (3) cyc(1'b0);
    rst_v = 1'b1;
    cyc(1'b0);
    check("rst_rempty", o_lcd_rempty, 1);
    check("rst_busy", o_busy, 0);
    check("rst_fifo_rinc", o_fifo_rinc, 0);
    check("rst_underrun", o_underrun, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_src", o_src, 0);

    r0 = rinc_total;
    push_host(8'h00, FB);
    run_frame("host");
    check("host_rinc_count", rinc_total - r0, FB);
    check("host_src", done_src, 0);
    check("host_src_hold", o_src, 0);

    for (int e = 0; e < 4; e++) begin
      r0 = rinc_total;
      cyc(1'b0, 1'b1, pat_tab[e].sel);
      push_pattern(pat_tab[e].sel);
      run_frame($sformatf("pat%0d", e));
      check("pat_src", done_src, 1);
      check("pat_src_hold", o_src, 1);
      check("pat_no_rinc", rinc_total - r0, 0);
    end

    r0 = rinc_total;
    cyc(1'b0, 1'b1, 2'd3);
    fifo_q.push_back(8'hC0); fifo_q.push_back(8'hC1); fifo_q.push_back(8'hC2);
    push_pattern(2'd3);
    run_frame("pat_fifo_full");
    check("pat_fifo_level", fifo_q.size(), 3);
    check("pat_fifo_rinc", rinc_total - r0, 0);
    check("pat_fifo_src", done_src, 1);

    exp_q.push_back(8'hC0); exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
    push_host(8'hD3, FB - 3);
    run_frame("host_preempt", FB, 3, 2'd0, 5, 2'd2);
    check("preempt_host_src", done_src, 0);
    check("one_idle_gap_busy", o_busy, 1);
    check("one_idle_gap_src", o_src, 1);
    push_pattern(2'd2);
    run_frame("pat_after_host");
    check("pat_after_host_src", done_src, 1);

    push_host(8'hE0, 4);
    got = 0;
    for (int k = 0; k < 50 && got < 4; k++) begin
      cyc(1'b1);
      if (last_acc) got++;
    end
    check("stall_pre_bytes", got, 4);
    repeat (1023) cyc(1'b1);
    cyc(1'b1);
    check("underrun_before_timeout", o_underrun, 0);
    cyc(1'b1);
    check("underrun_at_timeout", o_underrun, WD_EN);
    check("stall_busy", o_busy, 1);
    push_host(8'hF4, FB - 4);
    run_frame("host_resume", FB - 4);
    check("underrun_sticky", o_underrun, WD_EN);
    check("resume_src", done_src, 0);

    cyc(1'b0, 1'b1, 2'd1);
    push_pattern(2'd1);
    got = 0;
    for (int k = 0; k < 50 && got < 8; k++) begin
      cyc(1'b1);
      if (last_acc) got++;
    end
    check("abort_pre_bytes", got, 8);
    rst_v = 1'b0;
    cyc(1'b0);
    rst_v = 1'b1;
    cyc(1'b0);
    exp_q.delete();
    check("abort_busy", o_busy, 0);
    check("abort_rempty", o_lcd_rempty, 1);
    check("abort_done", o_frame_done, 0);
    check("abort_underrun", o_underrun, 0);
    check("abort_src", o_src, 0);
    busy_seen = 0;
    repeat (4) begin
      cyc(1'b0);
      if (o_busy !== 1'b0 || o_frame_done !== 1'b0) busy_seen++;
    end
    check("abort_no_pend", busy_seen, 0);
    cyc(1'b0, 1'b1, 2'd3);
    push_pattern(2'd3);
    run_frame("ramp_after_reset");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

endmodule
